// File: rtl/reg_skid_reader.sv
// Two-entry registered skid buffer: IN_READY, OUT_VALID and DOUT all come straight from flops.
// Optional occupancy output LEVEL is enabled by defining SKID_LEVEL_EN.
module reg_skid_reader #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  CLK,
  input  logic                  ARST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] DIN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] DOUT
`ifdef SKID_LEVEL_EN
  ,
  output logic [1:0]            LEVEL
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_n;
  logic [DATA_WIDTH-1:0]   main_r;
  logic [DATA_WIDTH-1:0]   main_n;
  logic [DATA_WIDTH-1:0]   skid_r;
  logic [DATA_WIDTH-1:0]   skid_n;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic                    in_fire_s;
  logic                    out_fire_s;

  // Fires use only the registered handshake flags, so no input reaches an output combinationally.
  assign in_fire_s  = IN_VALID & in_ready_r;
  assign out_fire_s = out_valid_r & OUT_READY;

  // Next-state and datapath selection.
  always_comb begin
    state_n = state_r;
    main_n  = main_r;
    skid_n  = skid_r;
    case (state_r)
      EMPTY: begin
        if (in_fire_s) begin
          state_n = BUSY;
          main_n  = DIN;
        end else begin
          state_n = EMPTY;
        end
      end
      BUSY: begin
        if (in_fire_s && out_fire_s) begin
          main_n = DIN;
        end else if (in_fire_s) begin
          state_n = FULL;
          skid_n  = DIN;
        end else if (out_fire_s) begin
          state_n = EMPTY;
        end else begin
          state_n = BUSY;
        end
      end
      FULL: begin
        if (out_fire_s) begin
          state_n = BUSY;
          main_n  = skid_r;
        end else begin
          state_n = FULL;
        end
      end
      default: begin
        state_n = EMPTY;
      end
    endcase
  end

  // State, storage and the handshake flags, the latter pre-decoded from the next state.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state_r     <= EMPTY;
      main_r      <= {DATA_WIDTH{1'b0}};
      skid_r      <= {DATA_WIDTH{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      main_r      <= main_n;
      skid_r      <= skid_n;
      in_ready_r  <= (state_n != FULL);
      out_valid_r <= (state_n != EMPTY);
    end
  end

  assign IN_READY  = in_ready_r;
  assign OUT_VALID = out_valid_r;
  assign DOUT      = main_r;

`ifdef SKID_LEVEL_EN
  logic [1:0] level_r;

  // Occupancy count, updated on the same edge as the state.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      level_r <= 2'd0;
    end else begin
      case (state_n)
        EMPTY:   level_r <= 2'd0;
        BUSY:    level_r <= 2'd1;
        FULL:    level_r <= 2'd2;
        default: level_r <= 2'd0;
      endcase
    end
  end

  assign LEVEL = level_r;
`endif

endmodule
